// File: rtl/tswitch_pkg.sv
// Shared switch constants for the reduction datapath.
package tswitch_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned TAG_WIDTH  = 8;

endpackage

// File: rtl/response_collector_if.sv
// Start, per-port response and value-stream handshakes of the response collector.
interface response_collector_if #(
  parameter int unsigned NUM_PORTS = 4
);

  localparam int unsigned DATA_W    = tswitch_pkg::DATA_WIDTH;
  localparam int unsigned TAG_W     = tswitch_pkg::TAG_WIDTH;
  localparam int unsigned PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic                          start_valid;
  logic [TAG_W-1:0]              start_tag;
  logic [NUM_PORTS-1:0]          start_mask;
  logic [PORT_BITS-1:0]          start_src_port;
  logic                          start_ready;

  logic [NUM_PORTS-1:0]          resp_valid;
  logic [NUM_PORTS*DATA_W-1:0]   resp_data;
  logic [NUM_PORTS*TAG_W-1:0]    resp_tag;
  logic [NUM_PORTS-1:0]          resp_ready;

  logic                          value_valid;
  logic [DATA_W-1:0]             value_data;
  logic [TAG_W-1:0]              value_tag;
  logic                          value_last;
  logic [PORT_BITS-1:0]          value_src_port;
  logic                          value_ready;

  // Collector side
  modport master (
    input  start_valid, start_tag, start_mask, start_src_port,
    input  resp_valid, resp_data, resp_tag,
    input  value_ready,
    output start_ready, resp_ready,
    output value_valid, value_data, value_tag, value_last, value_src_port
  );

  // Requester / responders / reduction engine side
  modport slave (
    output start_valid, start_tag, start_mask, start_src_port,
    output resp_valid, resp_data, resp_tag,
    output value_ready,
    input  start_ready, resp_ready,
    input  value_valid, value_data, value_tag, value_last, value_src_port
  );

endinterface

// File: rtl/response_collector.sv
// Gathers one BF16 response per participating port for a single reduction tag,
// then streams the buffered values lowest port first to the reduction engine.
module response_collector #(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  response_collector_if.master  bus,
  output logic                  busy,
  output logic                  err_pulse
);

  localparam int unsigned DATA_W    = tswitch_pkg::DATA_WIDTH;
  localparam int unsigned TAG_W     = tswitch_pkg::TAG_WIDTH;
  localparam int unsigned PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t                            state;
  logic [TAG_W-1:0]                  tag_q;
  logic [NUM_PORTS-1:0]              mask_q;
  logic [NUM_PORTS-1:0]              received_q;
  logic [NUM_PORTS-1:0]              remaining_q;
  logic [PORT_BITS-1:0]              src_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  data_buf;

  logic                              start_ready_q;
  logic [NUM_PORTS-1:0]              resp_ready_q;
  logic                              value_valid_q;
  logic [DATA_W-1:0]                 value_data_q;
  logic                              value_last_q;
  logic                              busy_q;
  logic                              err_q;

  logic [NUM_PORTS-1:0]              match_acc;
  logic [NUM_PORTS-1:0]              mism_acc;
  logic [NUM_PORTS-1:0]              recv_next;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  buf_next;
  logic [PORT_BITS-1:0]              ptr;
  logic [NUM_PORTS-1:0]              rem_after;

  function automatic logic [PORT_BITS-1:0] lowest(input logic [NUM_PORTS-1:0] v);
    logic [PORT_BITS-1:0] r;
    r = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (v[i]) r = PORT_BITS'(i);
    end
    return r;
  endfunction

  function automatic logic single_bit(input logic [NUM_PORTS-1:0] v);
    return (v != '0) && ((v & (v - NUM_PORTS'(1))) == '0);
  endfunction

  // Classify this cycle's accepted responses and preview the buffer after the write
  always_comb begin
    match_acc = '0;
    mism_acc  = '0;
    buf_next  = data_buf;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if ((state == S_COLLECT) && bus.resp_valid[p] && resp_ready_q[p]) begin
        if (bus.resp_tag[p*TAG_W +: TAG_W] == tag_q) begin
          match_acc[p] = 1'b1;
          buf_next[p]  = bus.resp_data[p*DATA_W +: DATA_W];
        end else begin
          mism_acc[p] = 1'b1;
        end
      end
    end
    recv_next = received_q | match_acc;
    ptr       = lowest(remaining_q);
    rem_after = remaining_q & ~(NUM_PORTS'(1) << ptr);
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      tag_q         <= '0;
      mask_q        <= '0;
      received_q    <= '0;
      remaining_q   <= '0;
      src_q         <= '0;
      data_buf      <= '0;
      start_ready_q <= 1'b1;
      resp_ready_q  <= '0;
      value_valid_q <= 1'b0;
      value_data_q  <= '0;
      value_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_valid) begin
            tag_q      <= bus.start_tag;
            mask_q     <= bus.start_mask;
            src_q      <= bus.start_src_port;
            received_q <= '0;
            if (bus.start_mask != '0) begin
              state         <= S_COLLECT;
              start_ready_q <= 1'b0;
              busy_q        <= 1'b1;
              resp_ready_q  <= bus.start_mask;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          data_buf   <= buf_next;
          received_q <= recv_next;
          if (mism_acc != '0) err_q <= 1'b1;
          // Mismatched responses leave their port open for a retry
          if (recv_next == mask_q) begin
            state         <= S_DRAIN;
            resp_ready_q  <= '0;
            remaining_q   <= mask_q;
            value_valid_q <= 1'b1;
            value_data_q  <= buf_next[lowest(mask_q)];
            value_last_q  <= single_bit(mask_q);
          end else begin
            resp_ready_q <= mask_q & ~recv_next;
          end
        end

        S_DRAIN: begin
          if (bus.value_ready) begin
            remaining_q <= rem_after;
            if (rem_after == '0) begin
              state         <= S_IDLE;
              value_valid_q <= 1'b0;
              value_last_q  <= 1'b0;
              start_ready_q <= 1'b1;
              busy_q        <= 1'b0;
            end else begin
              value_data_q <= data_buf[lowest(rem_after)];
              value_last_q <= single_bit(rem_after);
            end
          end
        end

        default: begin
          state         <= S_IDLE;
          start_ready_q <= 1'b1;
          resp_ready_q  <= '0;
          value_valid_q <= 1'b0;
          value_last_q  <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready    = start_ready_q;
  assign bus.resp_ready     = resp_ready_q;
  assign bus.value_valid    = value_valid_q;
  assign bus.value_data     = value_data_q;
  assign bus.value_tag      = tag_q;
  assign bus.value_last     = value_last_q;
  assign bus.value_src_port = src_q;
  assign busy               = busy_q;
  assign err_pulse          = err_q;

endmodule

// File: tb/tb_response_collector.sv
// Scoreboard bench for response_collector: expected beats queued at stimulus time,
// popped and compared on every accepted value beat.
module tb_response_collector;

  import tswitch_pkg::*;

  localparam int NP = 4;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  tag;
    logic        last;
    logic [1:0]  src;
  } beat_t;

  logic clk;
  logic rst_n;
  logic busy;
  logic err_pulse;

  beat_t exp_q[$];
  int    n_checks  = 0;
  int    n_fail    = 0;
  int    n_pushed  = 0;
  int    n_flushed = 0;
  int    beat_cnt  = 0;
  int    err_cnt   = 0;

  response_collector_if #(.NUM_PORTS(NP)) bus ();

  response_collector #(.NUM_PORTS(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .err_pulse (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_resp(input int p, input logic v, input logic [7:0] t, input logic [15:0] d);
    bus.resp_valid[p] = v;
    bus.resp_tag[p*TAG_WIDTH +: TAG_WIDTH]    = t;
    bus.resp_data[p*DATA_WIDTH +: DATA_WIDTH] = d;
  endtask

  task automatic idle_inputs();
    bus.start_valid    = 1'b0;
    bus.start_tag      = '0;
    bus.start_mask     = '0;
    bus.start_src_port = '0;
    bus.resp_valid     = '0;
    bus.resp_data      = '0;
    bus.resp_tag       = '0;
  endtask

  task automatic start_req(input logic [7:0] t, input logic [3:0] m, input logic [1:0] s);
    bus.start_valid    = 1'b1;
    bus.start_tag      = t;
    bus.start_mask     = m;
    bus.start_src_port = s;
    tick();
    bus.start_valid    = 1'b0;
  endtask

  // Expected beats in port order; last flag on the highest participating port
  task automatic push_exp(input logic [7:0] t, input logic [3:0] m, input logic [1:0] s,
                          input logic [3:0][15:0] d);
    int    hi;
    beat_t b;
    hi = -1;
    for (int p = 0; p < NP; p++) if (m[p]) hi = p;
    for (int p = 0; p < NP; p++) begin
      if (m[p]) begin
        b.data = d[p];
        b.tag  = t;
        b.last = (p == hi);
        b.src  = s;
        exp_q.push_back(b);
        n_pushed++;
      end
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_done_busy", busy, 0);
  endtask

  // Value-stream monitor, sampled mid-cycle
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && err_pulse) err_cnt++;
    if (rst_n && bus.value_valid && bus.value_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        beat_cnt++;
        check("beat_data", bus.value_data, e.data);
        check("beat_tag",  bus.value_tag,  e.tag);
        check("beat_last", bus.value_last, e.last);
        check("beat_src",  bus.value_src_port, e.src);
      end
    end
  end

  task automatic run_basic(input bit backpressure);
    push_exp(8'h05, 4'b1011, 2'd2, {16'h4000, 16'h0000, 16'h4040, 16'h3F80});
    start_req(8'h05, 4'b1011, 2'd2);
    check("c1_busy", busy, 1);
    check("c1_start_ready", bus.start_ready, 0);
    check("c1_resp_ready", bus.resp_ready, 4'b1011);
    tick();
    set_resp(3, 1'b1, 8'h05, 16'h4000);
    tick();
    set_resp(3, 1'b0, 8'h00, 16'h0000);
    check("c3_resp_ready", bus.resp_ready, 4'b0011);
    check("c3_value_valid", bus.value_valid, 0);
    set_resp(0, 1'b1, 8'h05, 16'h3F80);
    set_resp(1, 1'b1, 8'h05, 16'h4040);
    if (backpressure) bus.value_ready = 1'b0;
    tick();
    set_resp(0, 1'b0, 8'h00, 16'h0000);
    set_resp(1, 1'b0, 8'h00, 16'h0000);
    check("c4_value_valid", bus.value_valid, 1);
    check("c4_value_data", bus.value_data, 16'h3F80);
    check("c4_resp_ready", bus.resp_ready, 4'b0000);
    if (backpressure) begin
      for (int i = 0; i < 2; i++) begin
        tick();
        check("bp_hold_valid", bus.value_valid, 1);
        check("bp_hold_data", bus.value_data, 16'h3F80);
        check("bp_hold_last", bus.value_last, 0);
      end
      tick();
      bus.value_ready = 1'b1;
      wait_idle(20);
      check("bp_start_ready", bus.start_ready, 1);
    end else begin
      tick();
      tick();
      check("c6_busy", busy, 1);
      check("c6_last", bus.value_last, 1);
      tick();
      check("c7_busy", busy, 0);
      check("c7_start_ready", bus.start_ready, 1);
      check("c7_value_valid", bus.value_valid, 0);
    end
  endtask

  initial begin
    int err0;
    rst_n = 1'b0;
    bus.value_ready = 1'b1;
    idle_inputs();
    #12;
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_resp_ready", bus.resp_ready, 0);
    check("rst_value_valid", bus.value_valid, 0);
    check("rst_value_last", bus.value_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_pulse, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_basic(1'b0);
    run_basic(1'b1);

    // Tag mismatch is consumed, flagged, and the port stays open
    err0 = err_cnt;
    push_exp(8'h05, 4'b0001, 2'd0, {16'h0000, 16'h0000, 16'h0000, 16'h3F80});
    start_req(8'h05, 4'b0001, 2'd0);
    set_resp(0, 1'b1, 8'h06, 16'h1234);
    tick();
    check("mm_err_pulse", err_pulse, 1);
    check("mm_resp_ready", bus.resp_ready, 4'b0001);
    check("mm_value_valid", bus.value_valid, 0);
    set_resp(0, 1'b1, 8'h05, 16'h3F80);
    tick();
    set_resp(0, 1'b0, 8'h00, 16'h0000);
    check("mm_err_clear", err_pulse, 0);
    check("mm_value_valid2", bus.value_valid, 1);
    check("mm_value_last", bus.value_last, 1);
    wait_idle(10);
    check("mm_err_count", err_cnt - err0, 1);

    // Single port
    push_exp(8'h21, 4'b0100, 2'd3, {16'h0000, 16'hBF80, 16'h0000, 16'h0000});
    start_req(8'h21, 4'b0100, 2'd3);
    set_resp(2, 1'b1, 8'h21, 16'hBF80);
    tick();
    set_resp(2, 1'b0, 8'h00, 16'h0000);
    check("sp_value_valid", bus.value_valid, 1);
    check("sp_value_last", bus.value_last, 1);
    wait_idle(10);

    // Empty mask
    err0 = err_cnt;
    start_req(8'h07, 4'b0000, 2'd1);
    check("em_err_pulse", err_pulse, 1);
    check("em_busy", busy, 0);
    check("em_start_ready", bus.start_ready, 1);
    tick();
    check("em_err_clear", err_pulse, 0);
    for (int i = 0; i < 3; i++) tick();
    check("em_busy_after", busy, 0);
    check("em_value_valid", bus.value_valid, 0);
    check("em_err_count", err_cnt - err0, 1);

    // Reset after the first beat of a 3-port reduction
    push_exp(8'h33, 4'b0111, 2'd1, {16'h0000, 16'hC000, 16'h4000, 16'h3F80});
    start_req(8'h33, 4'b0111, 2'd1);
    set_resp(0, 1'b1, 8'h33, 16'h3F80);
    set_resp(1, 1'b1, 8'h33, 16'h4000);
    set_resp(2, 1'b1, 8'h33, 16'hC000);
    tick();
    idle_inputs();
    check("rd_first_valid", bus.value_valid, 1);
    tick();
    check("rd_second_data", bus.value_data, 16'h4000);
    rst_n = 1'b0;
    #1;
    check("rd_valid_drop", bus.value_valid, 0);
    check("rd_busy_drop", busy, 0);
    n_flushed += exp_q.size();
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rd_start_ready", bus.start_ready, 1);
    check("rd_value_valid", bus.value_valid, 0);
    run_basic(1'b0);

    // Duplicate and non-member responses are never accepted
    push_exp(8'h44, 4'b0011, 2'd0, {16'h0000, 16'h0000, 16'h4100, 16'h3F00});
    start_req(8'h44, 4'b0011, 2'd0);
    check("du_resp_ready1", bus.resp_ready, 4'b0011);
    set_resp(0, 1'b1, 8'h44, 16'h3F00);
    set_resp(2, 1'b1, 8'h44, 16'hDEAD);
    tick();
    check("du_resp_ready2", bus.resp_ready, 4'b0010);
    set_resp(0, 1'b1, 8'h44, 16'hBEEF);
    set_resp(1, 1'b1, 8'h44, 16'h4100);
    tick();
    check("du_resp_ready3", bus.resp_ready, 4'b0000);
    check("du_value_valid", bus.value_valid, 1);
    wait_idle(10);
    idle_inputs();
    tick();

    check("sb_empty", exp_q.size(), 0);
    check("beat_total", beat_cnt, n_pushed - n_flushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
